// File: rtl/pipelined_shifter_if.sv
// Issue/broadcast bundle for the pipelined funnel shifter, plus the RS tag type shared with the CDB.
typedef enum logic [2:0] {
    NO_VAL  = 3'd0,
    ALU_1   = 3'd1,
    ALU_2   = 3'd2,
    MUL_1   = 3'd3,
    SHIFT_1 = 3'd4,
    LSU_1   = 3'd5
} rs_tag_t;

interface pipelined_shifter_if #(
    parameter int unsigned DWIDTH = 32
);
    logic              valid_i;
    logic              ready_o;
    logic [2:0]        op_i;
    logic [DWIDTH-1:0] rs1_val_i;
    logic [DWIDTH-1:0] rs2_val_i;
    logic              flush_i;
    logic              grant_i;
    logic              cdb_valid_o;
    rs_tag_t           cdb_tag_o;
    logic [DWIDTH-1:0] cdb_val_o;

    modport master (
        output valid_i, op_i, rs1_val_i, rs2_val_i, flush_i, grant_i,
        input  ready_o, cdb_valid_o, cdb_tag_o, cdb_val_o
    );

    modport slave (
        input  valid_i, op_i, rs1_val_i, rs2_val_i, flush_i, grant_i,
        output ready_o, cdb_valid_o, cdb_tag_o, cdb_val_o
    );
endinterface

// File: rtl/pipelined_shifter.sv
// Pipelined funnel shifter (SLL/SRL/SRA/ROL/ROR) for the SHIFT RS slot; one shamt group per stage,
// last stage registers straight into the CDB output with grant back-pressure and flush.
module pipelined_shifter #(
    parameter int unsigned DWIDTH = 32,
    parameter int unsigned STAGES = 2,
    parameter rs_tag_t     TAG    = SHIFT_1
) (
    input logic                clk_i,
    input logic                reset_i,
    pipelined_shifter_if.slave bus
);
    localparam int unsigned SB = $clog2(DWIDTH);
    localparam int unsigned FW = 2 * DWIDTH - 1;
    localparam int unsigned NR = (STAGES > 1) ? STAGES - 1 : 1;

    typedef enum logic [2:0] {
        OP_SLL = 3'd0,
        OP_SRL = 3'd1,
        OP_SRA = 3'd2,
        OP_ROL = 3'd3,
        OP_ROR = 3'd4
    } op_t;

    // Stage k owns a contiguous group of shamt bits; MSB group first, leftover bits go to early stages.
    function automatic logic [SB-1:0] group_mask(int unsigned k);
        logic [SB-1:0] m;
        int unsigned   top;
        int unsigned   sz;
        m   = '0;
        top = SB;
        for (int unsigned j = 0; j < STAGES; j++) begin
            sz = SB / STAGES + ((j < SB % STAGES) ? 32'd1 : 32'd0);
            if (j == k) begin
                for (int unsigned b = top - sz; b < top; b++) begin
                    m = m | (SB'(1) << b);
                end
            end
            top = top - sz;
        end
        return m;
    endfunction

    function automatic logic [SB-1:0] eff_amt(logic left, logic [SB-1:0] shamt);
        return left ? ~shamt : shamt;
    endfunction

    op_t           op;
    logic          stall;
    logic          accept;
    logic          legal;
    logic          unused_rs2;

    logic [FW-1:0] in_fun   [STAGES];
    logic [SB-1:0] in_shamt [STAGES];
    logic          in_left  [STAGES];
    logic          in_vld   [STAGES];

    logic [FW-1:0] r_fun    [NR];
    logic [SB-1:0] r_shamt  [NR];
    logic          r_left   [NR];
    logic          r_vld    [NR];

    always_comb begin
        op          = op_t'(bus.op_i);
        stall       = bus.cdb_valid_o && !bus.grant_i;
        bus.ready_o = !stall;
        legal       = (bus.op_i <= 3'd4);
        accept      = bus.valid_i && !stall;
        unused_rs2  = ^bus.rs2_val_i[DWIDTH-1:SB];

        in_fun[0] = '0;
        case (op)
            OP_SRL:  in_fun[0] = {{(DWIDTH-1){1'b0}}, bus.rs1_val_i};
            OP_SRA:  in_fun[0] = {{(DWIDTH-1){bus.rs1_val_i[DWIDTH-1]}}, bus.rs1_val_i};
            OP_ROR:  in_fun[0] = {bus.rs1_val_i[DWIDTH-2:0], bus.rs1_val_i};
            OP_SLL:  in_fun[0] = {bus.rs1_val_i, {(DWIDTH-1){1'b0}}};
            OP_ROL:  in_fun[0] = {bus.rs1_val_i, bus.rs1_val_i[DWIDTH-1:1]};
            default: in_fun[0] = '0;
        endcase
        in_shamt[0] = bus.rs2_val_i[SB-1:0];
        in_left[0]  = (op == OP_SLL) || (op == OP_ROL);
        // Illegal ops are accepted but never set a valid bit, so they become bubbles.
        in_vld[0]   = accept && legal;

        for (int unsigned k = 1; k < STAGES; k++) begin
            in_fun[k]   = r_fun[k-1];
            in_shamt[k] = r_shamt[k-1];
            in_left[k]  = r_left[k-1];
            in_vld[k]   = r_vld[k-1];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            for (int unsigned k = 0; k < NR; k++) begin
                r_vld[k] <= 1'b0;
            end
            bus.cdb_valid_o <= 1'b0;
            bus.cdb_tag_o   <= NO_VAL;
            bus.cdb_val_o   <= '0;
        end else if (bus.flush_i) begin
            for (int unsigned k = 0; k < NR; k++) begin
                r_vld[k] <= 1'b0;
            end
            bus.cdb_valid_o <= 1'b0;
            bus.cdb_tag_o   <= NO_VAL;
        end else if (!stall) begin
            for (int unsigned k = 0; k < STAGES - 1; k++) begin
                r_fun[k]   <= in_fun[k] >> (eff_amt(in_left[k], in_shamt[k]) & group_mask(k));
                r_shamt[k] <= in_shamt[k];
                r_left[k]  <= in_left[k];
                r_vld[k]   <= in_vld[k];
            end
            bus.cdb_valid_o <= in_vld[STAGES-1];
            bus.cdb_tag_o   <= in_vld[STAGES-1] ? TAG : NO_VAL;
            bus.cdb_val_o   <= DWIDTH'(in_fun[STAGES-1] >>
                               (eff_amt(in_left[STAGES-1], in_shamt[STAGES-1]) & group_mask(STAGES-1)));
        end
    end
endmodule
